// File: rtl/d5m_pkg.sv
// d5m_pkg: state encoding, pattern codes and Bayer constants shared by the D5M stream generator
package d5m_pkg;
  typedef enum logic [2:0] {IDLE, FV_LEAD, LINE, HBLANK, FV_TAIL, VBLANK} d5m_gen_state_t;
  localparam logic [1:0] PAT_RAMP = 2'd0;
  localparam logic [1:0] PAT_BAYER = 2'd1;
  localparam logic [1:0] PAT_FRAMEID = 2'd2;
  localparam logic [1:0] PAT_ZERO = 2'd3;
  localparam logic [11:0] G_VAL = 12'h800;
  localparam logic [11:0] R_VAL = 12'hFFF;
  localparam logic [11:0] B_VAL = 12'h100;
endpackage

// File: rtl/d5m_pattern_pixel.sv
// d5m_pattern_pixel: combinational test-pattern pixel for position (x, y) in frame f
module d5m_pattern_pixel import d5m_pkg::*; #(
  parameter int dataWidth = 12,
  parameter int img_width = 64
) (
  input  logic [15:0]          x,
  input  logic [15:0]          y,
  input  logic [3:0]           f,
  input  logic [1:0]           sel,
  output logic [dataWidth-1:0] pix
);
  localparam int SH = dataWidth < 12 ? 12 - dataWidth : 0;
  localparam logic [dataWidth-1:0] G = dataWidth'(G_VAL >> SH);
  localparam logic [dataWidth-1:0] R = dataWidth'(R_VAL >> SH);
  localparam logic [dataWidth-1:0] B = dataWidth'(B_VAL >> SH);
  logic [dataWidth-1:0] ramp;
  logic [dataWidth-1:0] bayer;
  assign ramp = dataWidth'(32'(x) + 32'(y) * 32'(img_width));
  assign bayer = y[0] ? (x[0] ? G : B) : (x[0] ? R : G);
  always_comb begin
    pix = sel == PAT_RAMP    ? ramp :
          sel == PAT_BAYER   ? bayer :
          sel == PAT_FRAMEID ? {f, x[dataWidth-5:0]} : '0;
  end
endmodule

// File: rtl/d5m_camera_stream_gen.sv
// d5m_camera_stream_gen: D5M-style ifval/ilval/idata frame generator with programmable timing and test patterns
module d5m_camera_stream_gen import d5m_pkg::*; #(
  parameter int dataWidth  = 12,
  parameter int img_width  = 64,
  parameter int img_height = 16,
  parameter int h_blank    = 8,
  parameter int fv_lead    = 4,
  parameter int fv_tail    = 4,
  parameter int v_blank    = 16
) (
  input  logic                 pixclk,
  input  logic                 ARESETN,
  input  logic                 enable,
  input  logic [1:0]           pattern_sel,
  output logic                 ifval,
  output logic                 ilval,
  output logic [dataWidth-1:0] idata,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic                 busy
);
  if (img_width < 2 || img_height < 2 || h_blank < 1 || fv_lead < 1 || fv_tail < 1 || v_blank < 1 || dataWidth < 5 ||
      (img_width | img_height | h_blank | fv_lead | fv_tail | v_blank) > 65535) begin : g_param_err
    $fatal(1, "d5m_camera_stream_gen: illegal timing or width parameters");
  end
  d5m_gen_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, y_q, y_d, len, frame_count_q, frame_count_d;
  logic [1:0] sel_q, sel_d;
  logic ifval_q, ifval_d, ilval_q, ilval_d, frame_done_q, frame_done_d, busy_q, busy_d, last;
  logic [dataWidth-1:0] idata_q, idata_d, pix;
  assign len = state_q == FV_LEAD ? 16'(fv_lead) :
               state_q == LINE    ? 16'(img_width) :
               state_q == HBLANK  ? 16'(h_blank) :
               state_q == FV_TAIL ? 16'(fv_tail) : 16'(v_blank);
  assign last = cnt_q == len - 16'd1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 16'd1;
    y_d = y_q;
    sel_d = sel_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = FV_LEAD;
          sel_d = pattern_sel;
          y_d = '0;
        end
      end
      FV_LEAD: if (last) begin
        state_d = LINE;
        cnt_d = '0;
      end
      LINE: if (last) begin
        cnt_d = '0;
        state_d = y_q == 16'(img_height - 1) ? FV_TAIL : HBLANK;
        y_d = y_q == 16'(img_height - 1) ? y_q : y_q + 16'd1;
      end
      HBLANK: if (last) begin
        state_d = LINE;
        cnt_d = '0;
      end
      FV_TAIL: if (last) begin
        state_d = VBLANK;
        cnt_d = '0;
      end
      VBLANK: if (last) begin
        cnt_d = '0;
        y_d = '0;
        state_d = enable ? FV_LEAD : IDLE;
        sel_d = enable ? pattern_sel : sel_q;
      end
      default: state_d = IDLE;
    endcase
    ifval_d = state_d inside {FV_LEAD, LINE, HBLANK, FV_TAIL};
    ilval_d = state_d == LINE;
    busy_d = state_d != IDLE;
    frame_done_d = state_q == FV_TAIL && state_d == VBLANK;
    frame_count_d = frame_count_q + 16'(frame_done_d);
    idata_d = ilval_d ? pix : '0;
  end
  // pixel is computed for the next cycle's position so idata lands in the same cycle as ilval
  d5m_pattern_pixel #(.dataWidth(dataWidth), .img_width(img_width)) u_pix (
    .x(cnt_d),
    .y(y_d),
    .f(frame_count_q[3:0]),
    .sel(sel_d),
    .pix(pix)
  );
  always_ff @(posedge pixclk or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      y_q <= '0;
      sel_q <= PAT_RAMP;
      ifval_q <= 1'b0;
      ilval_q <= 1'b0;
      idata_q <= '0;
      frame_done_q <= 1'b0;
      frame_count_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      y_q <= y_d;
      sel_q <= sel_d;
      ifval_q <= ifval_d;
      ilval_q <= ilval_d;
      idata_q <= idata_d;
      frame_done_q <= frame_done_d;
      frame_count_q <= frame_count_d;
      busy_q <= busy_d;
    end
  end
  assign ifval = ifval_q;
  assign ilval = ilval_q;
  assign idata = idata_q;
  assign frame_done = frame_done_q;
  assign frame_count = frame_count_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_d5m_camera_stream_gen.sv
// tb_d5m_camera_stream_gen: directed and randomized checks against a frame-position reference model
module tb_d5m_camera_stream_gen;
  localparam int W = 8, H = 4, HB = 3, LEAD = 2, TAIL = 2, VB = 5, DW = 12;
  localparam int BODY = H * W + (H - 1) * HB;
  localparam int DONE_P = LEAD + BODY + TAIL;
  localparam int P = DONE_P + VB;
  logic pixclk = 1'b0, ARESETN = 1'b0, enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic ifval, ilval, frame_done, busy;
  logic [DW-1:0] idata;
  logic [15:0] frame_count;
  int checks = 0, errors = 0;
  bit m_run = 1'b0;
  int m_p = 0;
  logic [1:0] m_sel = 2'd0;
  logic [15:0] m_fc = 16'd0;

  d5m_camera_stream_gen #(.dataWidth(DW), .img_width(W), .img_height(H), .h_blank(HB),
                          .fv_lead(LEAD), .fv_tail(TAIL), .v_blank(VB)) dut (
    .pixclk(pixclk), .ARESETN(ARESETN), .enable(enable), .pattern_sel(pattern_sel),
    .ifval(ifval), .ilval(ilval), .idata(idata), .frame_done(frame_done),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 pixclk = ~pixclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pix(input int x, input int y, input logic [15:0] f, input logic [1:0] s);
    case (s)
      2'd0: return 12'(x + y * W);
      2'd1: return (y % 2 == 0) ? ((x % 2 == 0) ? 12'h800 : 12'hFFF) : ((x % 2 == 0) ? 12'h100 : 12'h800);
      2'd2: return {f[3:0], 8'(x)};
      default: return 12'h000;
    endcase
  endfunction

  task automatic model_step();
    if (!m_run) begin
      if (enable) begin
        m_run = 1'b1;
        m_p = 0;
        m_sel = pattern_sel;
      end
    end else begin
      m_p++;
      if (m_p == P) begin
        if (enable) begin
          m_p = 0;
          m_sel = pattern_sel;
        end else m_run = 1'b0;
      end
    end
    if (m_run && m_p == DONE_P) m_fc++;
  endtask

  task automatic check_outputs();
    logic e_fv, e_lv, e_done;
    logic [11:0] e_d;
    int q, x, y;
    e_fv = 1'b0; e_lv = 1'b0; e_done = 1'b0; e_d = '0;
    if (m_run) begin
      e_fv = m_p < DONE_P;
      e_done = m_p == DONE_P;
      if (m_p >= LEAD && m_p < LEAD + BODY) begin
        q = m_p - LEAD;
        x = q % (W + HB);
        y = q / (W + HB);
        if (x < W) begin
          e_lv = 1'b1;
          e_d = ref_pix(x, y, m_fc, m_sel);
        end
      end
    end
    chk("ifval", 32'(ifval), 32'(e_fv));
    chk("ilval", 32'(ilval), 32'(e_lv));
    chk("idata", 32'(idata), 32'(e_d));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    chk("busy", 32'(busy), 32'(m_run));
  endtask

  task automatic tick();
    @(posedge pixclk);
    model_step();
    #1 check_outputs();
  endtask

  task automatic do_reset();
    #1 ARESETN = 1'b0;
    #1 m_run = 1'b0;
    m_fc = 16'd0;
    check_outputs();
    @(negedge pixclk);
    ARESETN = 1'b1;
  endtask

  initial begin
    #12 check_outputs();
    @(negedge pixclk);
    ARESETN = 1'b1;
    tick();
    tick();
    enable = 1'b1;
    for (int c = 1; c <= 160; c++) begin
      tick();
      if (c == 1) chk("fv_rise", 32'(ifval), 32'd1);
      if (c == 2) chk("lead_no_lv", 32'(ilval), 32'd0);
      if (c == 3) chk("first_lv", 32'(ilval), 32'd1);
      if (c == 27) chk("ramp_line2", 32'(idata), 32'd18);
      if (c == 46) begin
        chk("fv_fall", 32'(ifval), 32'd0);
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("count_1", 32'(frame_count), 32'd1);
      end
      if (c == 51) chk("fv_rise2", 32'(ifval), 32'd1);
      if (c == 64) chk("sel_ignored", 32'(idata), 32'd8);
      if (c == 103) chk("bayer_g", 32'(idata), 32'h800);
      if (c == 104) chk("bayer_r", 32'(idata), 32'hFFF);
      if (c == 114) chk("bayer_b", 32'(idata), 32'h100);
      if (c == 146) chk("count_3", 32'(frame_count), 32'd3);
      if (c == 150) chk("vblank_busy", 32'(busy), 32'd1);
      if (c == 151) chk("idle_busy", 32'(busy), 32'd0);
      if (c == 155) chk("idle_fv", 32'(ifval), 32'd0);
      if (c == 60) pattern_sel = 2'd1;
      if (c == 116) enable = 1'b0;
    end
    enable = 1'b1;
    pattern_sel = 2'd2;
    for (int d = 1; d <= 12; d++) begin
      tick();
      if (d == 1) chk("fv_after_idle", 32'(ifval), 32'd1);
      if (d == 5) chk("frameid_hi", 32'(idata[11:8]), 32'd3);
      if (d == 8) begin
        chk("lv_before_rst", 32'(ilval), 32'd1);
        enable = 1'b0;
        do_reset();
        chk("rst_count", 32'(frame_count), 32'd0);
      end
    end
    enable = 1'b1;
    tick();
    chk("restart_fv", 32'(ifval), 32'd1);
    tick();
    tick();
    chk("restart_lv", 32'(ilval), 32'd1);
    for (int i = 0; i < 3000; i++) begin
      tick();
      enable = $urandom_range(0, 9) < 8;
      pattern_sel = 2'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
